// File: rtl/mat_conv_pkg.sv
`default_nettype none
// ============================================================================
// Module : mat_conv_pkg
// Brief  : Shared pixel/word types and sequencer state encoding.
// Rev    : 1.0  initial release
// ============================================================================
package mat_conv_pkg;

  localparam int PIXEL_BITS  = 8;
  localparam int FIFO_WIDTH  = 8;
  localparam int c_WORD_BITS = PIXEL_BITS * FIFO_WIDTH;

  typedef logic [PIXEL_BITS-1:0] pixel_t;
  typedef pixel_t [FIFO_WIDTH-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/sync_word_fifo.sv
`default_nettype none
// ============================================================================
// Module : sync_word_fifo
// Brief  : Registered-output-free word FIFO; head is visible the cycle after push.
// Rev    : 1.0  initial release
// ============================================================================
module sync_word_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 65
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_push,
  input  logic [DATA_W-1:0]       i_wdata,
  input  logic                    i_pop,
  output logic [DATA_W-1:0]       o_rdata,
  output logic [$clog2(DEPTH):0]  o_count,
  output logic                    o_empty
);

  localparam int            c_AW    = $clog2(DEPTH);
  localparam logic [c_AW:0] c_DEPTH = (c_AW + 1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]   r_wr_ptr;
  logic [c_AW-1:0]   r_rd_ptr;
  logic [c_AW:0]     r_count;
  logic              w_full;
  logic              w_push;
  logic              w_pop;

  assign w_full  = (r_count == c_DEPTH);
  assign o_empty = (r_count == '0);
  assign w_push  = i_push & ~w_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers are exactly log2(DEPTH) bits so they wrap on their own.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/pixel_word_sequencer.sv
`default_nettype none
// ============================================================================
// Module : pixel_word_sequencer
// Brief  : Buffers pixel words and drives cluster_feeder load/shift controls.
// Rev    : 1.0  initial release
// ============================================================================
module pixel_word_sequencer
  import mat_conv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic [FIFO_WIDTH*PIXEL_BITS-1:0] i_wdata,
  input  logic                             i_wlast,
  input  logic                             i_wvalid,
  output logic                             o_wready,
  output logic [PIXEL_BITS-1:0]            o_pixel_0,
  output logic [PIXEL_BITS-1:0]            o_pixel_1,
  output logic [PIXEL_BITS-1:0]            o_pixel_2,
  output logic [PIXEL_BITS-1:0]            o_pixel_3,
  output logic [PIXEL_BITS-1:0]            o_pixel_4,
  output logic [PIXEL_BITS-1:0]            o_pixel_5,
  output logic [PIXEL_BITS-1:0]            o_pixel_6,
  output logic [PIXEL_BITS-1:0]            o_pixel_7,
  output logic                             o_sel,
  output logic                             o_new,
  output logic                             o_window_valid,
  output logic                             o_row_end
);

  localparam int                  c_AW       = $clog2(DEPTH);
  localparam int                  c_CNT_W    = $clog2(FIFO_WIDTH);
  localparam logic [c_CNT_W-1:0]  c_CNT_LAST = c_CNT_W'(FIFO_WIDTH - 2);
  localparam logic [c_AW:0]       c_DEPTH    = (c_AW + 1)'(DEPTH);

  seq_state_e           r_state;
  seq_state_e           w_state_nxt;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [c_CNT_W-1:0]   w_cnt_nxt;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_empty;
  logic                 w_last_shift;
  logic [c_AW:0]        w_count;
  logic [c_WORD_BITS:0] w_head;
  word_t                r_pixel;
  logic                 r_last;
  logic                 r_window_valid;
  logic                 r_row_end;

  assign o_wready = (w_count < c_DEPTH);
  assign w_push   = i_wvalid & o_wready;

  sync_word_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (c_WORD_BITS + 1)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_wdata ({i_wlast, i_wdata}),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_count (w_count),
    .o_empty (w_empty)
  );

  assign w_last_shift = (r_state == SHIFT) && (r_cnt == c_CNT_LAST);

  // The pop is issued on the same edge that enters LOAD, so the next word
  // can follow the last SHIFT cycle with no gap.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pop       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_state_nxt = LOAD;
          w_pop       = 1'b1;
        end
      end
      LOAD: begin
        w_state_nxt = SHIFT;
        w_cnt_nxt   = '0;
      end
      SHIFT: begin
        if (w_last_shift) begin
          w_cnt_nxt = '0;
          if (!w_empty) begin
            w_state_nxt = LOAD;
            w_pop       = 1'b1;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Qualifiers lag the state by one cycle to match the feeder output latency.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pixel        <= '0;
      r_last         <= 1'b0;
      r_window_valid <= 1'b0;
      r_row_end      <= 1'b0;
    end else begin
      if (w_pop) begin
        r_pixel <= word_t'(w_head[c_WORD_BITS-1:0]);
        r_last  <= w_head[c_WORD_BITS];
      end
      r_window_valid <= (r_state == LOAD) || (r_state == SHIFT);
      r_row_end      <= w_last_shift & r_last;
    end
  end

  assign o_sel          = (r_state == LOAD);
  assign o_new          = o_sel;
  assign o_window_valid = r_window_valid;
  assign o_row_end      = r_row_end;

  assign o_pixel_0 = r_pixel[0];
  assign o_pixel_1 = r_pixel[1];
  assign o_pixel_2 = r_pixel[2];
  assign o_pixel_3 = r_pixel[3];
  assign o_pixel_4 = r_pixel[4];
  assign o_pixel_5 = r_pixel[5];
  assign o_pixel_6 = r_pixel[6];
  assign o_pixel_7 = r_pixel[7];

endmodule
`default_nettype wire

// File: tb/tb_pixel_word_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_pixel_word_sequencer
// Brief  : Directed table and sequence checks for pixel_word_sequencer.
// Rev    : 1.0  initial release
// ============================================================================
module tb_pixel_word_sequencer;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic [63:0] i_wdata;
  logic        i_wlast;
  logic        i_wvalid;
  logic        o_wready;
  logic [7:0]  o_pixel_0, o_pixel_1, o_pixel_2, o_pixel_3;
  logic [7:0]  o_pixel_4, o_pixel_5, o_pixel_6, o_pixel_7;
  logic        o_sel, o_new, o_window_valid, o_row_end;

  always #5 i_clk = ~i_clk;

  pixel_word_sequencer #(.DEPTH(4)) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_wdata        (i_wdata),
    .i_wlast        (i_wlast),
    .i_wvalid       (i_wvalid),
    .o_wready       (o_wready),
    .o_pixel_0      (o_pixel_0),
    .o_pixel_1      (o_pixel_1),
    .o_pixel_2      (o_pixel_2),
    .o_pixel_3      (o_pixel_3),
    .o_pixel_4      (o_pixel_4),
    .o_pixel_5      (o_pixel_5),
    .o_pixel_6      (o_pixel_6),
    .o_pixel_7      (o_pixel_7),
    .o_sel          (o_sel),
    .o_new          (o_new),
    .o_window_valid (o_window_valid),
    .o_row_end      (o_row_end)
  );

  typedef struct {
    logic        wvalid;
    logic        wlast;
    logic [63:0] wdata;
    logic        sel;
    logic        wv;
    logic        re;
    logic        rdy;
    logic [63:0] pix;
  } vec_t;

  vec_t        vq[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] tx_data[$];
  logic        tx_last[$];
  int          tx_cyc[$];
  int          exp_load[$];
  logic        h_sel[64], h_new[64], h_wv[64], h_re[64], h_rdy[64];
  logic [63:0] h_pix[64];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pix_now();
    return {o_pixel_7, o_pixel_6, o_pixel_5, o_pixel_4,
            o_pixel_3, o_pixel_2, o_pixel_1, o_pixel_0};
  endfunction

  function automatic logic [63:0] ctl_now();
    return 64'({o_sel, o_new, o_window_valid, o_row_end, o_wready});
  endfunction

  task automatic add(input logic wvi, input logic wl, input logic [63:0] wd,
                     input logic sel, input logic wv, input logic re,
                     input logic rdy, input logic [63:0] pix);
    vec_t v;
    v = '{wvi, wl, wd, sel, wv, re, rdy, pix};
    vq.push_back(v);
  endtask

  task automatic idle_inputs();
    i_wvalid = 1'b0;
    i_wlast  = 1'b0;
    i_wdata  = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    chk("reset_ctl", ctl_now(), 64'h1);
    chk("reset_pix", pix_now(), 64'h0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  // Each vector: outputs sampled at a falling edge, then its inputs are driven
  // for the following rising edge.
  task automatic run_table(input string tag);
    foreach (vq[i]) begin
      @(negedge i_clk);
      chk($sformatf("%s_vec%0d_ctl", tag, i), ctl_now(),
          64'({vq[i].sel, vq[i].sel, vq[i].wv, vq[i].re, vq[i].rdy}));
      chk($sformatf("%s_vec%0d_pix", tag, i), pix_now(), vq[i].pix);
      i_wvalid = vq[i].wvalid;
      i_wlast  = vq[i].wlast;
      i_wdata  = vq[i].wdata;
    end
    idle_inputs();
    vq.delete();
  endtask

  task automatic clear_tx();
    tx_data.delete();
    tx_last.delete();
    tx_cyc.delete();
    exp_load.delete();
  endtask

  task automatic push_tx(input logic [63:0] d, input logic l, input int c);
    tx_data.push_back(d);
    tx_last.push_back(l);
    tx_cyc.push_back(c);
  endtask

  // Word k is offered from cycle tx_cyc[k] on and held until accepted.
  task automatic run_stream(input string tag, input int ncyc);
    int idx = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge i_clk);
      if (idx < tx_data.size() && c >= tx_cyc[idx]) begin
        i_wvalid = 1'b1;
        i_wdata  = tx_data[idx];
        i_wlast  = tx_last[idx];
      end else begin
        idle_inputs();
      end
      h_sel[c] = o_sel;
      h_new[c] = o_new;
      h_wv[c]  = o_window_valid;
      h_re[c]  = o_row_end;
      h_rdy[c] = o_wready;
      h_pix[c] = pix_now();
      if (i_wvalid && o_wready) idx++;
    end
    idle_inputs();
    chk($sformatf("%s_accepted", tag), 64'(idx), 64'(tx_data.size()));
  endtask

  task automatic check_loads(input string tag, input int ncyc);
    int k = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (h_sel[c]) begin
        if (k < exp_load.size()) begin
          chk($sformatf("%s_load%0d_cycle", tag, k), 64'(c), 64'(exp_load[k]));
          chk($sformatf("%s_load%0d_word", tag, k), h_pix[c], tx_data[k]);
          chk($sformatf("%s_load%0d_new", tag, k), 64'(h_new[c]), 64'h1);
        end
        k++;
      end
    end
    chk($sformatf("%s_nloads", tag), 64'(k), 64'(exp_load.size()));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] wa, wb, wc;
    logic [18:0] rdy_exp;
    int first, last, cnt;
    i_rst_n = 1'b0;
    idle_inputs();

    // Single word, no row end
    do_reset();
    wa = 64'hBEEF50B3BEEF50B3;
    add('1, '0, wa,  '0, '0, '0, '1, '0);
    add('0, '0, '0,  '0, '0, '0, '1, '0);
    add('0, '0, '0,  '1, '0, '0, '1, wa);
    for (int i = 0; i < 8; i++) add('0, '0, '0, '0, '1, '0, '1, wa);
    add('0, '0, '0,  '0, '0, '0, '1, wa);
    add('0, '0, '0,  '0, '0, '0, '1, wa);
    run_table("t1");

    // Row-end word followed by a plain word
    do_reset();
    wb = 64'h1122334455667788;
    wc = 64'h99AABBCCDDEEFF00;
    add('1, '1, wb,  '0, '0, '0, '1, '0);
    add('1, '0, wc,  '0, '0, '0, '1, '0);
    add('0, '0, '0,  '1, '0, '0, '1, wb);
    for (int i = 0; i < 7; i++) add('0, '0, '0, '0, '1, '0, '1, wb);
    add('0, '0, '0,  '1, '1, '1, '1, wc);
    for (int i = 0; i < 8; i++) add('0, '0, '0, '0, '1, '0, '1, wc);
    add('0, '0, '0,  '0, '0, '0, '1, wc);
    run_table("t4");

    // Three words back-to-back
    do_reset();
    clear_tx();
    push_tx(64'hA0A1A2A3A4A5A6A7, 1'b0, 0);
    push_tx(64'hB0B1B2B3B4B5B6B7, 1'b0, 0);
    push_tx(64'hC0C1C2C3C4C5C6C7, 1'b0, 0);
    exp_load = '{2, 10, 18};
    run_stream("t2", 40);
    check_loads("t2", 40);
    first = -1; last = -1; cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (h_wv[c]) begin
        if (first < 0) first = c;
        last = c;
        cnt++;
      end
    end
    chk("t2_wv_count", 64'(cnt), 64'd24);
    chk("t2_wv_first", 64'(first), 64'd3);
    chk("t2_wv_span", 64'(last - first + 1), 64'd24);

    // Six words with valid held: FIFO fills and back-pressures
    do_reset();
    clear_tx();
    for (int k = 0; k < 6; k++) push_tx({8{8'(8'h10 * (k + 1))}}, 1'b0, 0);
    exp_load = '{2, 10, 18, 26, 34, 42};
    rdy_exp = 19'b1_0000000_1_00000_11111;
    run_stream("t3", 60);
    for (int c = 0; c < 19; c++)
      chk($sformatf("t3_wready_c%0d", c), 64'(h_rdy[c]), 64'(rdy_exp[c]));
    check_loads("t3", 60);

    // Asynchronous reset mid-word with two words still queued
    do_reset();
    clear_tx();
    push_tx(64'h5555555555555555, 1'b0, 0);
    push_tx(64'h6666666666666666, 1'b0, 0);
    push_tx(64'h7777777777777777, 1'b0, 0);
    run_stream("t5a", 6);
    chk("t5_pre_load", 64'(h_sel[2]), 64'h1);
    chk("t5_pre_wv", 64'(h_wv[5]), 64'h1);
    i_rst_n = 1'b0;
    #1;
    chk("t5_async_ctl", ctl_now(), 64'h1);
    chk("t5_async_pix", pix_now(), 64'h0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    clear_tx();
    run_stream("t5_idle", 8);
    check_loads("t5_idle", 8);
    chk("t5_idle_wv", 64'(h_wv[4]), 64'h0);
    push_tx(64'h0706050403020100, 1'b0, 0);
    exp_load = '{2};
    run_stream("t5b", 14);
    check_loads("t5b", 14);

    // Push during the final SHIFT cycle with the FIFO otherwise empty
    do_reset();
    clear_tx();
    push_tx(64'hD1D2D3D4D5D6D7D8, 1'b0, 0);
    push_tx(64'hE1E2E3E4E5E6E7E8, 1'b0, 9);
    exp_load = '{2, 11};
    run_stream("t6", 25);
    check_loads("t6", 25);
    chk("t6_wv_c10", 64'(h_wv[10]), 64'h1);
    chk("t6_wv_c11", 64'(h_wv[11]), 64'h0);
    chk("t6_wv_c12", 64'(h_wv[12]), 64'h1);
    cnt = 0;
    for (int c = 3; c < 20; c++) if (!h_wv[c]) cnt++;
    chk("t6_wv_gap", 64'(cnt), 64'd1);
    cnt = 0;
    for (int c = 0; c < 25; c++) if (h_re[c]) cnt++;
    chk("t6_no_row_end", 64'(cnt), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
